alu_seq: RTL and testbench

Parametrised sequential ALU; successor to the 8-bit combinational datapath ALU.
- Adds: configurable width, registered outputs, start/ready/done handshake, SUB, an iterative shift-add multiplier, iterative logical-left and arithmetic-right shifts, and ZERO/CARRY flags.
- Sits between register file and writeback in the CPU model; the control unit issues one operation per START.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_iter_unit.sv | 75 +++++++
 rtl/alu_seq.sv | 117 +++++++++++
 tb/tb_alu_seq.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_pkg;

   localparam logic [2:0] ALU_FWD = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRA = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   function automatic logic is_shift(input logic [2:0] op);
      return (op == ALU_SLL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   // Handshake: a request is taken at a rising edge where START && READY;
   // SELECT/DATA1/DATA2 are sampled only then. DONE is a one-cycle pulse
   // marking the edge at which RESULT/ZERO/CARRY were updated; they hold after.
   logic             START;
   logic [2:0]       SELECT;
   logic [WIDTH-1:0] DATA1;
   logic [WIDTH-1:0] DATA2;
   logic             READY;
   logic [WIDTH-1:0] RESULT;
   logic             DONE;
   logic             ZERO;
   logic             CARRY;

   modport master (
      output START, SELECT, DATA1, DATA2,
      input  READY, RESULT, DONE, ZERO, CARRY
   );

   modport slave (
      input  START, SELECT, DATA1, DATA2,
      output READY, RESULT, DONE, ZERO, CARRY
   );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative engine for MUL (shift-add), SLL and SRA: one step per cycle,
// last_o marks the step whose result_o/carry_o are final.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           load_i,
   input  logic [2:0]                     op_i,
   input  logic [WIDTH-1:0]               a_i,
   input  logic [WIDTH-1:0]               b_i,
   input  logic [$clog2(WIDTH):0]         shamt_i,
   output logic                           last_o,
   output logic [WIDTH-1:0]               result_o,
   output logic                           carry_o
);

   localparam int SHAMT_W = $clog2(WIDTH) + 1;

   logic [2:0]         op_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic               sout_q, sout_d;

   always_comb begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      sh_d     = sh_q;
      sout_d   = sout_q;
      // SLL drops the MSB; SRA drops the LSB and re-injects the sign bit.
      if (op_q == ALU_SLL) begin
         {sout_d, sh_d} = {sh_q, 1'b0};
      end else begin
         {sh_d, sout_d} = {sh_q[WIDTH-1], sh_q};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q     <= ALU_FWD;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sh_q     <= '0;
         sout_q   <= 1'b0;
      end else if (load_i) begin
         op_q     <= op_i;
         cnt_q    <= (op_i == ALU_MUL) ? SHAMT_W'(WIDTH) : shamt_i;
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         mplier_q <= b_i;
         sh_q     <= a_i;
         sout_q   <= 1'b0;
      end else if (cnt_q != '0) begin
         cnt_q    <= cnt_q - SHAMT_W'(1);
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sh_q     <= sh_d;
         sout_q   <= sout_d;
      end
   end

   assign last_o   = (cnt_q == SHAMT_W'(1));
   assign result_o = (op_q == ALU_MUL) ? acc_d[WIDTH-1:0] : sh_d;
   assign carry_o  = (op_q == ALU_MUL) ? (acc_d[2*WIDTH-1:WIDTH] != '0) : sout_d;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: single-cycle ops computed here, MUL/shifts delegated
// to alu_iter_unit; all outputs registered and updated with a DONE pulse.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic      CLK,
   input  logic      RESET,
   alu_seq_if.slave  bus,
   output state_e    dbg_state_o
);

   localparam int               SHAMT_W = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] W_LIM   = WIDTH'(WIDTH);

   state_e             state_q;
   logic [WIDTH-1:0]   result_q;
   logic               done_q;
   logic               zero_q;
   logic               carry_q;

   logic               accept;
   logic               is_multi;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH:0]     wide;
   logic [WIDTH-1:0]   sc_res_d;
   logic               sc_carry_d;

   logic               iter_last;
   logic [WIDTH-1:0]   iter_res;
   logic               iter_carry;

   assign accept   = bus.START && (state_q == ST_IDLE);
   assign shamt    = (bus.DATA2 >= W_LIM) ? SHAMT_W'(WIDTH) : SHAMT_W'(bus.DATA2);
   assign is_multi = (bus.SELECT == ALU_MUL) || (is_shift(bus.SELECT) && (bus.DATA2 != '0));

   always_comb begin
      wide       = '0;
      sc_res_d   = '0;
      sc_carry_d = 1'b0;
      case (bus.SELECT)
         ALU_FWD: sc_res_d = bus.DATA2;
         ALU_ADD: begin
            wide       = {1'b0, bus.DATA1} + {1'b0, bus.DATA2};
            sc_res_d   = wide[WIDTH-1:0];
            sc_carry_d = wide[WIDTH];
         end
         ALU_AND: sc_res_d = bus.DATA1 & bus.DATA2;
         ALU_OR:  sc_res_d = bus.DATA1 | bus.DATA2;
         ALU_SUB: begin
            // The extra MSB of the widened difference is the borrow.
            wide       = {1'b0, bus.DATA1} - {1'b0, bus.DATA2};
            sc_res_d   = wide[WIDTH-1:0];
            sc_carry_d = wide[WIDTH];
         end
         default: sc_res_d = bus.DATA1;  // shift by zero passes DATA1 through
      endcase
   end

   alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
      .clk_i    (CLK),
      .rst_i    (RESET),
      .load_i   (accept && is_multi),
      .op_i     (bus.SELECT),
      .a_i      (bus.DATA1),
      .b_i      (bus.DATA2),
      .shamt_i  (shamt),
      .last_o   (iter_last),
      .result_o (iter_res),
      .carry_o  (iter_carry)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         done_q   <= 1'b0;
         zero_q   <= 1'b1;
         carry_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_multi) begin
                     state_q <= ST_BUSY;
                  end else begin
                     result_q <= sc_res_d;
                     carry_q  <= sc_carry_d;
                     zero_q   <= (sc_res_d == '0);
                     done_q   <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               if (iter_last) begin
                  result_q <= iter_res;
                  carry_q  <= iter_carry;
                  zero_q   <= (iter_res == '0);
                  done_q   <= 1'b1;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.READY   = (state_q == ST_IDLE);
   assign bus.RESULT  = result_q;
   assign bus.DONE    = done_q;
   assign bus.ZERO    = zero_q;
   assign bus.CARRY   = carry_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: behavioural model + per-cycle compare, plus literal pins.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 8;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus_if();
   state_e dbg_state;

   alu_seq #(.WIDTH(W)) dut (
      .CLK         (clk),
      .RESET       (rst),
      .bus         (bus_if),
      .dbg_state_o (dbg_state)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
   endtask

   // behavioural model
   logic [W:0]   exp_q[$];
   int           m_left   = 0;
   logic [W-1:0] m_result = '0;
   logic         m_zero   = 1'b1;
   logic         m_carry  = 1'b0;
   logic         m_done   = 1'b0;

   function automatic void model_op(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] res, output logic cy, output int lat);
      logic [2*W-1:0] t;
      int amt;
      amt = (int'(b) >= W) ? W : int'(b);
      res = '0;
      cy  = 1'b0;
      lat = 0;
      case (sel)
         ALU_FWD: res = b;
         ALU_ADD: begin res = a + b; cy = (int'(a) + int'(b)) >= (1 << W); end
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_SUB: begin res = a - b; cy = (a < b); end
         ALU_MUL: begin t = a * b; res = t[W-1:0]; cy = (t[2*W-1:W] != '0); lat = W; end
         ALU_SLL: begin
            t = {{W{1'b0}}, a} << amt;
            res = t[W-1:0];
            cy = (amt == 0) ? 1'b0 : t[W];
            lat = amt;
         end
         default: begin
            t = $signed({a, {W{1'b0}}}) >>> amt;
            res = t[2*W-1:W];
            cy = (amt == 0) ? 1'b0 : t[W-1];
            lat = amt;
         end
      endcase
   endfunction

   function automatic void retire();
      {m_carry, m_result} = exp_q.pop_front();
      m_zero = (m_result == '0);
      m_done = 1'b1;
   endfunction

   always @(posedge clk) begin
      logic [W-1:0] r;
      logic c;
      int l;
      m_done = 1'b0;
      if (rst) begin
         m_left = 0; m_result = '0; m_zero = 1'b1; m_carry = 1'b0;
         exp_q.delete();
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) retire();
      end else if (bus_if.START) begin
         model_op(bus_if.SELECT, bus_if.DATA1, bus_if.DATA2, r, c, l);
         exp_q.push_back({c, r});
         if (l == 0) retire();
         else m_left = l;
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      check("ready",  bus_if.READY,  m_left == 0);
      check("done",   bus_if.DONE,   m_done);
      check("result", bus_if.RESULT, m_result);
      check("zero",   bus_if.ZERO,   m_zero);
      check("carry",  bus_if.CARRY,  m_carry);
      if (bus_if.DONE) done_cnt++;
   end

   // driver tasks: called at a negedge, return at the negedge after the accept edge
   task automatic drive(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
      bus_if.START  = 1'b1;
      bus_if.SELECT = sel;
      bus_if.DATA1  = a;
      bus_if.DATA2  = b;
      @(negedge clk);
   endtask

   task automatic stop_start();
      bus_if.START = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int lat);
      lat = 0;
      while (!bus_if.DONE && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      if (!bus_if.DONE) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input string name, input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int req_lat, input logic [W-1:0] req_res, input logic req_cy, input logic req_z);
      int lat;
      drive(sel, a, b);
      stop_start();
      wait_done(40, lat);
      check({name, "_lat"},    lat, req_lat);
      check({name, "_result"}, bus_if.RESULT, req_res);
      check({name, "_carry"},  bus_if.CARRY, req_cy);
      check({name, "_zero"},   bus_if.ZERO, req_z);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int d0, lat;
      bus_if.START = 1'b0; bus_if.SELECT = ALU_FWD; bus_if.DATA1 = '0; bus_if.DATA2 = '0;
      repeat (2) @(negedge clk);
      check("rst_result", bus_if.RESULT, 8'h00);
      check("rst_zero",   bus_if.ZERO,   1'b1);
      check("rst_carry",  bus_if.CARRY,  1'b0);
      check("rst_ready",  bus_if.READY,  1'b1);
      check("rst_done",   bus_if.DONE,   1'b0);
      rst = 1'b0;
      @(negedge clk);

      // reset during a MUL aborts it
      d0 = done_cnt;
      drive(ALU_MUL, 8'h0D, 8'h0B);
      stop_start();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_done_cnt", done_cnt - d0, 0);
      check("abort_result",   bus_if.RESULT, 8'h00);
      check("abort_zero",     bus_if.ZERO,   1'b1);
      check("abort_carry",    bus_if.CARRY,  1'b0);
      check("abort_ready",    bus_if.READY,  1'b1);

      // single-cycle arithmetic
      run_op("add_small", ALU_ADD, 8'h01, 8'h03, 0, 8'h04, 1'b0, 1'b0);
      @(negedge clk);
      check("add_done_pulse", bus_if.DONE, 1'b0);
      run_op("add_wrap",  ALU_ADD, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b1);
      run_op("sub_borrow", ALU_SUB, 8'h02, 8'h05, 0, 8'hFD, 1'b1, 1'b0);
      run_op("sub_plain", ALU_SUB, 8'h09, 8'h04, 0, 8'h05, 1'b0, 1'b0);

      // back-to-back single-cycle ops
      @(negedge clk);
      drive(ALU_AND, 8'hD5, 8'hEA);
      check("b2b_and_result", bus_if.RESULT, 8'hC0);
      check("b2b_and_done",   bus_if.DONE,   1'b1);
      check("b2b_and_ready",  bus_if.READY,  1'b1);
      drive(ALU_OR, 8'h01, 8'h02);
      check("b2b_or_result",  bus_if.RESULT, 8'h03);
      check("b2b_or_done",    bus_if.DONE,   1'b1);
      check("b2b_or_ready",   bus_if.READY,  1'b1);
      stop_start();
      @(negedge clk);
      check("b2b_done_drop",  bus_if.DONE,   1'b0);

      // multiplier
      run_op("mul_small", ALU_MUL, 8'h0D, 8'h0B, 8, 8'h8F, 1'b0, 1'b0);
      check("mul_ready_after", bus_if.READY, 1'b1);
      run_op("mul_ovf",   ALU_MUL, 8'h20, 8'h10, 8, 8'h00, 1'b1, 1'b1);
      run_op("mul_max",   ALU_MUL, 8'hFF, 8'hFF, 8, 8'h01, 1'b1, 1'b0);

      // shifts
      run_op("sll_3",   ALU_SLL, 8'h81, 8'd3,  3, 8'h08, 1'b0, 1'b0);
      run_op("sra_2",   ALU_SRA, 8'h80, 8'd2,  2, 8'hE0, 1'b0, 1'b0);
      run_op("sll_0",   ALU_SLL, 8'h5A, 8'd0,  0, 8'h5A, 1'b0, 1'b0);
      run_op("sll_12",  ALU_SLL, 8'hFF, 8'd12, 8, 8'h00, 1'b1, 1'b1);
      run_op("sra_1",   ALU_SRA, 8'hB3, 8'd1,  1, 8'hD9, 1'b1, 1'b0);
      run_op("sra_big", ALU_SRA, 8'h81, 8'hFF, 8, 8'hFF, 1'b1, 1'b0);

      // START held during BUSY is ignored
      @(negedge clk);
      d0 = done_cnt;
      drive(ALU_MUL, 8'h03, 8'h05);
      bus_if.SELECT = ALU_FWD;
      bus_if.DATA1  = 8'h00;
      bus_if.DATA2  = 8'h55;
      wait_done(40, lat);
      stop_start();
      check("busy_mul_lat",    lat, 8);
      check("busy_mul_result", bus_if.RESULT, 8'h0F);
      repeat (3) @(negedge clk);
      check("busy_done_cnt",   done_cnt - d0, 1);
      check("busy_hold",       bus_if.RESULT, 8'h0F);
      run_op("fwd_reissue", ALU_FWD, 8'h00, 8'h55, 0, 8'h55, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
